// File: rtl/spi_dev_regbus_pkg.sv
// spi_dev_regbus_pkg: state encodings, command/status bit positions and status packing
package spi_dev_regbus_pkg;
  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    CMD   = 4'd1,
    ADDR  = 4'd2,
    WDATA = 4'd3,
    WBUS  = 4'd4,
    RBUS  = 4'd5,
    RHOLD = 4'd6,
    DRAIN = 4'd7,
    ABORT = 4'd8
  } state_e;
  localparam int CMD_RD = 7;
  localparam int CMD_INC = 6;
  localparam int ST_OVR = 7;
  localparam int ST_UNR = 6;
  function automatic logic [7:0] status_byte(input logic ovr, input logic unr);
    logic [7:0] s;
    s = 8'h00;
    s[ST_OVR] = ovr;
    s[ST_UNR] = unr;
    return s;
  endfunction
endpackage

// File: rtl/spi_dev_regbus.sv
// spi_dev_regbus: frames SPI bytes into req/ack register-bus writes and prefetched reads
module spi_dev_regbus
  import spi_dev_regbus_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter logic [7:0] ERR_BYTE = 8'hEE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        usr_out,
  input  logic              usr_out_stb,
  output logic [7:0]        usr_in,
  input  logic              usr_in_ack,
  input  logic              csn_rise,
  input  logic              csn_fall,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  output logic              bus_we,
  output logic              bus_req,
  input  logic              bus_ack,
  input  logic [7:0]        bus_rdata,
  output logic              busy
);
  state_e state_q, state_d;
  logic rd_q, rd_d, inc_q, inc_d, we_q, we_d, req_q, req_d;
  logic ovr_q, ovr_d, unr_q, unr_d, busy_q, busy_d, fall_q, fall_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_nx;
  logic [7:0] wdata_q, wdata_d, usr_in_q, usr_in_d;
  assign addr_nx = addr_q + ADDR_W'(inc_q);
  assign usr_in = usr_in_q;
  assign bus_addr = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_we = we_q;
  assign bus_req = req_q;
  assign busy = busy_q;
  always_comb begin
    state_d = state_q;
    rd_d = rd_q;
    inc_d = inc_q;
    we_d = we_q;
    req_d = req_q;
    ovr_d = ovr_q;
    unr_d = unr_q;
    busy_d = busy_q;
    fall_d = fall_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    usr_in_d = usr_in_q;
    case (state_q)
      IDLE: begin
        if (csn_fall) begin
          state_d = CMD;
          busy_d = 1'b1;
          if (usr_in_ack) {ovr_d, unr_d} = 2'b00;
        end
      end
      CMD: begin
        if (usr_out_stb) begin
          rd_d = usr_out[CMD_RD];
          inc_d = usr_out[CMD_INC];
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (usr_out_stb) begin
          addr_d = usr_out[ADDR_W-1:0];
          req_d = rd_q;
          we_d = 1'b0;
          usr_in_d = ERR_BYTE;
          state_d = rd_q ? RBUS : WDATA;
        end
      end
      WDATA: begin
        if (usr_out_stb) begin
          req_d = 1'b1;
          we_d = 1'b1;
          wdata_d = usr_out;
          state_d = WBUS;
        end
      end
      WBUS: begin
        ovr_d = ovr_q | usr_out_stb;
        if (bus_ack) begin
          req_d = 1'b0;
          addr_d = addr_nx;
          state_d = WDATA;
        end
      end
      RBUS: begin
        unr_d = unr_q | usr_in_ack;
        if (bus_ack) begin
          req_d = 1'b0;
          usr_in_d = bus_rdata;
          state_d = RHOLD;
        end
      end
      RHOLD: begin
        if (usr_in_ack) begin
          addr_d = addr_nx;
          req_d = 1'b1;
          we_d = 1'b0;
          usr_in_d = ERR_BYTE;
          state_d = RBUS;
        end
      end
      ABORT: begin
        if (csn_fall) begin
          fall_d = 1'b1;
          if (usr_in_ack) {ovr_d, unr_d} = 2'b00;
        end
        if (bus_ack) begin
          req_d = 1'b0;
          state_d = fall_d ? CMD : IDLE;
          busy_d = fall_d;
          fall_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d = 1'b0;
      end
    endcase
    if (csn_rise) begin
      req_d = req_q && !bus_ack;
      state_d = req_d ? ABORT : IDLE;
      busy_d = req_d;
      fall_d = 1'b0;
    end
    if (state_d != RBUS && state_d != RHOLD) usr_in_d = status_byte(ovr_d, unr_d);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rd_q <= 1'b0;
      inc_q <= 1'b0;
      we_q <= 1'b0;
      req_q <= 1'b0;
      ovr_q <= 1'b0;
      unr_q <= 1'b0;
      busy_q <= 1'b0;
      fall_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= 8'h00;
      usr_in_q <= 8'h00;
    end else begin
      state_q <= state_d;
      rd_q <= rd_d;
      inc_q <= inc_d;
      we_q <= we_d;
      req_q <= req_d;
      ovr_q <= ovr_d;
      unr_q <= unr_d;
      busy_q <= busy_d;
      fall_q <= fall_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      usr_in_q <= usr_in_d;
    end
  end
endmodule

// File: tb/tb_spi_dev_regbus.sv
// tb_spi_dev_regbus: scoreboard bench acting as spi_dev_core and a latency-programmable register bus
module tb_spi_dev_regbus;
  localparam int G = 8;
  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] usr_out, usr_in, bus_rdata, bus_wdata, bus_addr;
  logic usr_out_stb, usr_in_ack, csn_rise, csn_fall, bus_we, bus_req, bus_ack, busy;
  logic [7:0] mem [256];
  logic [31:0] miso_q [$];
  logic [31:0] bus_q [$];
  int lat = 1;
  int cnt = 0;
  int total = 0;
  int passed = 0;
  spi_dev_regbus dut (
    .clk(clk), .rst_n(rst_n), .usr_out(usr_out), .usr_out_stb(usr_out_stb),
    .usr_in(usr_in), .usr_in_ack(usr_in_ack), .csn_rise(csn_rise), .csn_fall(csn_fall),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_req(bus_req),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic fall(input logic [7:0] exp0);
    @(negedge clk);
    csn_fall = 1'b1;
    usr_in_ack = 1'b1;
    miso_q.push_back(32'(exp0));
    @(negedge clk);
    csn_fall = 1'b0;
    usr_in_ack = 1'b0;
  endtask
  task automatic send(input logic [7:0] b, input logic ack, input logic [7:0] exp);
    step(G - 1);
    usr_out = b;
    usr_out_stb = 1'b1;
    usr_in_ack = ack;
    if (ack) miso_q.push_back(32'(exp));
    @(negedge clk);
    usr_out_stb = 1'b0;
    usr_in_ack = 1'b0;
  endtask
  task automatic rise();
    step(G - 1);
    csn_rise = 1'b1;
    @(negedge clk);
    csn_rise = 1'b0;
  endtask
  task automatic exp_bus(input logic we, input logic [7:0] a, input logic [7:0] d);
    bus_q.push_back(32'({we, a, we ? d : 8'h00}));
  endtask
  task automatic wait_idle(input string name);
    for (int i = 0; i < 60 && busy; i++) @(negedge clk);
    chk(name, 32'(busy), 32'd0);
  endtask
  initial begin
    bus_ack = 1'b0;
    bus_rdata = 8'h00;
    forever begin
      @(negedge clk);
      bus_ack = 1'b0;
      if (rst_n && bus_req && cnt == lat) begin
        bus_ack = 1'b1;
        bus_rdata = mem[bus_addr];
        if (bus_we) mem[bus_addr] = bus_wdata;
        cnt = 0;
      end else cnt = (rst_n && bus_req) ? cnt + 1 : 0;
    end
  end
  always begin
    @(negedge clk);
    #2;
    if (rst_n && usr_in_ack) begin
      if (miso_q.size() == 0) begin
        total++;
        $display("FAIL miso_extra: got %0h, expected no captured byte", usr_in);
      end else chk("miso", 32'(usr_in), miso_q.pop_front());
    end
    if (rst_n && bus_req && bus_ack) begin
      if (bus_q.size() == 0) begin
        total++;
        $display("FAIL bus_extra: got we=%0b addr=%0h, expected no access", bus_we, bus_addr);
      end else chk("bus", 32'({bus_we, bus_addr, bus_we ? bus_wdata : 8'h00}), bus_q.pop_front());
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst_n = 1'b0;
    usr_out = 8'h00;
    usr_out_stb = 1'b0;
    usr_in_ack = 1'b0;
    csn_rise = 1'b0;
    csn_fall = 1'b0;
    step(3);
    chk("rst_usr_in", 32'(usr_in), 32'h00);
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    step(2);
    lat = 1;
    fall(8'h00);
    chk("busy_after_fall", 32'(busy), 32'd1);
    send(8'h40, 1, 8'h00);
    send(8'h10, 1, 8'h00);
    send(8'hA1, 1, 8'h00);
    exp_bus(1, 8'h10, 8'hA1);
    send(8'hA2, 1, 8'h00);
    exp_bus(1, 8'h11, 8'hA2);
    send(8'hA3, 0, 8'h00);
    exp_bus(1, 8'h12, 8'hA3);
    rise();
    wait_idle("busy_wr_burst");
    mem[8'h05] = 8'h5A;
    lat = 2;
    fall(8'h00);
    send(8'h80, 1, 8'h00);
    send(8'h05, 1, 8'h00);
    exp_bus(0, 8'h05, 8'h00);
    send(8'h00, 1, 8'h5A);
    exp_bus(0, 8'h05, 8'h00);
    send(8'h00, 1, 8'h5A);
    exp_bus(0, 8'h05, 8'h00);
    send(8'h00, 0, 8'h00);
    rise();
    wait_idle("busy_rd_noinc");
    mem[8'hFF] = 8'hC3;
    mem[8'h00] = 8'h3C;
    mem[8'h01] = 8'h99;
    fall(8'h00);
    send(8'hC0, 1, 8'h00);
    send(8'hFF, 1, 8'h00);
    exp_bus(0, 8'hFF, 8'h00);
    send(8'h00, 1, 8'hC3);
    exp_bus(0, 8'h00, 8'h00);
    send(8'h00, 1, 8'h3C);
    exp_bus(0, 8'h01, 8'h00);
    send(8'h00, 0, 8'h00);
    rise();
    wait_idle("busy_rd_wrap");
    lat = 11;
    fall(8'h00);
    send(8'h80, 1, 8'h00);
    send(8'h05, 1, 8'h00);
    exp_bus(0, 8'h05, 8'h00);
    send(8'h00, 1, 8'hEE);
    send(8'h00, 0, 8'h00);
    rise();
    wait_idle("busy_slow");
    fall(8'h40);
    send(8'h00, 0, 8'h00);
    rise();
    wait_idle("busy_unr_clear");
    lat = 18;
    fall(8'h00);
    send(8'h00, 1, 8'h00);
    send(8'h20, 1, 8'h00);
    send(8'hB1, 1, 8'h00);
    exp_bus(1, 8'h20, 8'hB1);
    send(8'hB2, 0, 8'h00);
    rise();
    #2;
    chk("abort_req_held", 32'(bus_req), 32'd1);
    chk("abort_busy", 32'(busy), 32'd1);
    wait_idle("abort_done");
    chk("abort_req_low", 32'(bus_req), 32'd0);
    fall(8'h80);
    send(8'h80, 1, 8'h00);
    send(8'h05, 0, 8'h00);
    exp_bus(0, 8'h05, 8'h00);
    rise();
    fall(8'h00);
    chk("abort_fall_req", 32'(bus_req), 32'd1);
    step(15);
    lat = 1;
    chk("abort_fall_busy", 32'(busy), 32'd1);
    send(8'h00, 1, 8'h00);
    send(8'h30, 1, 8'h00);
    send(8'h77, 0, 8'h00);
    exp_bus(1, 8'h30, 8'h77);
    rise();
    wait_idle("busy_after_cmd");
    lat = 30;
    fall(8'h00);
    send(8'h40, 1, 8'h00);
    send(8'h40, 1, 8'h00);
    send(8'h11, 0, 8'h00);
    step(3);
    chk("mid_req", 32'(bus_req), 32'd1);
    chk("mid_addr", 32'(bus_addr), 32'h40);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req", 32'(bus_req), 32'd0);
    chk("rst_mid_we", 32'(bus_we), 32'd0);
    chk("rst_mid_addr", 32'(bus_addr), 32'h00);
    chk("rst_mid_wdata", 32'(bus_wdata), 32'h00);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_usr_in", 32'(usr_in), 32'h00);
    step(3);
    lat = 1;
    rst_n = 1'b1;
    step(2);
    fall(8'h00);
    send(8'h00, 1, 8'h00);
    send(8'h50, 1, 8'h00);
    send(8'h99, 0, 8'h00);
    exp_bus(1, 8'h50, 8'h99);
    rise();
    wait_idle("busy_final");
    step(10);
    chk("miso_drained", 32'(miso_q.size()), 32'd0);
    chk("bus_drained", 32'(bus_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
